// File: rtl/axis_noc_mux_shim_pkg.sv
// Shared NoC types for the AXIS <-> router local-port shim.
// Flit layout, arbiter states and width helpers.
package axis_noc_mux_shim_pkg;

  localparam int unsigned NOC_TDATA_W = 64;
  localparam int unsigned NOC_TID_W   = 2;
  localparam int unsigned NOC_TDEST_W = 4;
  localparam int unsigned NOC_DEST_W  = NOC_TID_W + NOC_TDEST_W;

  typedef struct packed {
    logic [NOC_TDATA_W-1:0] data;
    logic [NOC_DEST_W-1:0]  dest;
    logic                   is_tail;
  } noc_flit_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Bits to index n entries.
  function automatic int unsigned idx_w(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits to hold a count of 0..n.
  function automatic int unsigned cnt_w(int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axis_noc_mux_shim_fifo.sv
// Ejection flit FIFO: ring buffer with occupancy counter.
// A write while full is accepted only when a pop frees the slot.
module noc_flit_fifo
  import axis_noc_mux_shim_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter type         flit_t = noc_flit_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  wr_en_i,
  input  flit_t wr_data_i,
  input  logic  rd_en_i,
  output flit_t rd_data_o,
  output logic  empty_o,
  output logic  full_o
);

  localparam int unsigned PW = idx_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  flit_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign do_rd     = rd_en_i & ~empty_o;
  assign do_wr     = wr_en_i & (~full_o | do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_wr) wr_ptr_q <= wrap(wr_ptr_q);
      if (do_rd) rd_ptr_q <= wrap(rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/axis_noc_mux_shim.sv
// Muxes N AXIS streams onto one router local port (credit flow)
// and demuxes router ejection flits back onto per-channel streams.
module axis_noc_mux_shim
  import axis_noc_mux_shim_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS       = 4,
  parameter int unsigned TDATA_WIDTH        = NOC_TDATA_W,
  parameter int unsigned TDEST_WIDTH        = NOC_TDEST_W,
  parameter int unsigned TID_WIDTH          = NOC_TID_W,
  parameter int unsigned FLIT_BUFFER_DEPTH  = 2,
  parameter int unsigned EJECT_BUFFER_DEPTH = 4
) (
  input  logic                                     clk_noc,
  input  logic                                     rst_noc_sync,
  input  logic [NUM_CHANNELS-1:0]                  axis_in_tvalid,
  output logic [NUM_CHANNELS-1:0]                  axis_in_tready,
  input  logic [NUM_CHANNELS-1:0]                  axis_in_tlast,
  input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0] axis_in_tdata,
  input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]   axis_in_tid,
  input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0] axis_in_tdest,
  output logic [TDATA_WIDTH-1:0]                   data_out,
  output logic [TID_WIDTH+TDEST_WIDTH-1:0]         dest_out,
  output logic                                     is_tail_out,
  output logic                                     send_out,
  input  logic                                     credit_in,
  input  logic [TDATA_WIDTH-1:0]                   data_in,
  input  logic [TID_WIDTH+TDEST_WIDTH-1:0]         dest_in,
  input  logic                                     is_tail_in,
  input  logic                                     send_in,
  output logic                                     credit_out,
  output logic [NUM_CHANNELS-1:0]                  axis_out_tvalid,
  output logic [NUM_CHANNELS-1:0]                  axis_out_tlast,
  output logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0] axis_out_tdata,
  output logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]   axis_out_tid,
  output logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0] axis_out_tdest,
  input  logic [NUM_CHANNELS-1:0]                  axis_out_tready,
  output logic                                     overflow_err
);

  localparam int unsigned DW = TID_WIDTH + TDEST_WIDTH;
  localparam int unsigned GW = idx_w(NUM_CHANNELS);
  localparam int unsigned CW = cnt_w(FLIT_BUFFER_DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(FLIT_BUFFER_DEPTH);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [GW-1:0]     start;
  logic [GW-1:0]     pick;
  logic              pick_v;
  logic [NUM_CHANNELS-1:0] req;
  int                idx;
  logic              accept;
  logic              tail_acc;
  noc_flit_t         sel_flit;
  noc_flit_t         link_q;
  logic              send_q;

  function automatic logic [GW-1:0] nxt(input logic [GW-1:0] i);
    return (i == GW'(NUM_CHANNELS - 1)) ? '0 : i + GW'(1);
  endfunction

  // Round-robin search; a finishing channel yields to the others.
  always_comb begin
    req   = axis_in_tvalid;
    start = rr_q;
    if (state_q == ARB_LOCKED) begin
      start        = nxt(grant_q);
      req[grant_q] = 1'b0;
    end
    pick_v = 1'b0;
    pick   = '0;
    idx    = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      if (!pick_v && req[idx]) begin
        pick_v = 1'b1;
        pick   = GW'(idx);
      end
    end
  end

  assign accept   = |(axis_in_tvalid & axis_in_tready);
  assign tail_acc = accept & axis_in_tlast[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_v) begin
          state_d = ARB_LOCKED;
          grant_d = pick;
          rr_d    = nxt(pick);
        end
      end
      ARB_LOCKED: begin
        if (tail_acc) begin
          if (pick_v) begin
            grant_d = pick;
            rr_d    = nxt(pick);
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    credit_d = credit_q;
    unique case ({accept, credit_in})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: if (credit_q != CRED_MAX) credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_comb begin
    axis_in_tready = '0;
    if (state_q == ARB_LOCKED && credit_q != '0) begin
      axis_in_tready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    sel_flit.data    = axis_in_tdata[grant_q];
    sel_flit.dest    = {axis_in_tid[grant_q], axis_in_tdest[grant_q]};
    sel_flit.is_tail = axis_in_tlast[grant_q];
  end

  // Ejection side
  noc_flit_t            flit_in;
  noc_flit_t            head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic [TID_WIDTH-1:0] head_tid;
  logic                 head_ok;
  logic                 credit_out_q;
  logic                 ovf_q;

  assign flit_in.data    = data_in;
  assign flit_in.dest    = dest_in;
  assign flit_in.is_tail = is_tail_in;

  noc_flit_fifo #(
    .DEPTH  (EJECT_BUFFER_DEPTH),
    .flit_t (noc_flit_t)
  ) u_eject_fifo (
    .clk_i     (clk_noc),
    .rst_i     (rst_noc_sync),
    .wr_en_i   (send_in),
    .wr_data_i (flit_in),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign head_tid = head.dest[DW-1 -: TID_WIDTH];
  assign head_ok  = {1'b0, head_tid} < (TID_WIDTH + 1)'(NUM_CHANNELS);

  // Heads addressed past the last channel are dropped silently.
  always_comb begin
    axis_out_tvalid = '0;
    pop             = 1'b0;
    if (!fifo_empty) begin
      if (head_ok) begin
        axis_out_tvalid[head_tid] = 1'b1;
        pop = axis_out_tready[head_tid];
      end else begin
        pop = 1'b1;
      end
    end
  end

  assign axis_out_tdata = {NUM_CHANNELS{head.data}};
  assign axis_out_tid   = {NUM_CHANNELS{head_tid}};
  assign axis_out_tdest = {NUM_CHANNELS{head.dest[TDEST_WIDTH-1:0]}};
  assign axis_out_tlast = {NUM_CHANNELS{head.is_tail}};

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      rr_q         <= '0;
      credit_q     <= CRED_MAX;
      send_q       <= 1'b0;
      credit_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      credit_q     <= credit_d;
      send_q       <= accept;
      credit_out_q <= pop;
      ovf_q        <= ovf_q | (send_in & fifo_full & ~pop);
    end
  end

  always_ff @(posedge clk_noc) begin
    if (accept) link_q <= sel_flit;
  end

  assign send_out     = send_q;
  assign data_out     = link_q.data;
  assign dest_out     = link_q.dest;
  assign is_tail_out  = link_q.is_tail;
  assign credit_out   = credit_out_q;
  assign overflow_err = ovf_q;

endmodule
